// File: rtl/multi_read_responder.sv
// -----------------------------------------------------------------------------
// multi_read_responder
//
// RAM-side responder for the windowed read controllers. One start pulse brings
// in NUM_LANES packed addresses plus a mask. The reads are then issued one per
// cycle into a single-port synchronous BRAM. The returned words are gathered
// into a packed output bus, and o_validRam pulses once the last lane has landed.
//
// Ports
//   i_clk        clock, rising edge
//   i_reset      asynchronous active-low reset
//   i_startRam   request strobe, sampled in IDLE only
//   i_addrRead   packed lane addresses, lane k = [k*ADDR_W +: ADDR_W]
//   i_mask       1: fetch all lanes, 0: fetch lane 0 only (others read 0)
//   o_memAddr    BRAM read address
//   o_memRead    BRAM read enable
//   i_memData    BRAM read data, valid RD_LATENCY cycles after o_memRead
//   o_data       packed results, lane k = [k*DATA_W +: DATA_W]
//   o_validRam   one-cycle pulse: o_data complete
//   o_busy       request in progress (state != IDLE)
// -----------------------------------------------------------------------------

// Per-lane result register. Cleared on request acceptance, loaded on capture.
module multi_read_responder_lane #(
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clr,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_data
);
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (i_clr)
            data_d = '0;
        else if (i_wr)
            data_d = i_wdata;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) data_q <= '0;
        else          data_q <= data_d;
    end

    assign o_data = data_q;
endmodule

module multi_read_responder #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int NUM_LANES  = 9,
    parameter int RD_LATENCY = 1
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_startRam,
    input  logic [NUM_LANES*ADDR_W-1:0]   i_addrRead,
    input  logic                          i_mask,
    output logic [ADDR_W-1:0]             o_memAddr,
    output logic                          o_memRead,
    input  logic [DATA_W-1:0]             i_memData,
    output logic [NUM_LANES*DATA_W-1:0]   o_data,
    output logic                          o_validRam,
    output logic                          o_busy
);
    localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    // All pipe stages except the emerging one. When none of them holds a
    // valid entry, the read being captured this cycle is the last one.
    localparam logic [RD_LATENCY-1:0] MID_MASK = {RD_LATENCY{1'b1}} >> 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [NUM_LANES-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]                 last_q, last_d;
    logic [IDX_W-1:0]                 cnt_q, cnt_d;

    // Read-return tracking: {valid, lane index} travels alongside each read.
    logic [RD_LATENCY-1:0]             vld_pipe_q, vld_pipe_d;
    logic [RD_LATENCY-1:0][IDX_W-1:0]  idx_pipe_q, idx_pipe_d;

    logic                             start_acc;
    logic                             issue;
    logic                             cap_en;
    logic [IDX_W-1:0]                 cap_idx;
    logic                             pipe_mid_busy;
    logic [NUM_LANES-1:0][DATA_W-1:0] lane_data;

    assign start_acc     = (state_q == S_IDLE) && i_startRam;
    assign issue         = (state_q == S_ISSUE);
    assign cap_idx       = idx_pipe_q[RD_LATENCY-1];
    assign cap_en        = vld_pipe_q[RD_LATENCY-1] &&
                           ((state_q == S_ISSUE) || (state_q == S_DRAIN));
    assign pipe_mid_busy = |(vld_pipe_q & MID_MASK);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_startRam)     state_d = S_ISSUE;
            S_ISSUE: if (cnt_q == last_q) state_d = S_DRAIN;
            S_DRAIN: if (!pipe_mid_busy) state_d = S_DONE;
            S_DONE:                      state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_memRead  = issue;
        o_memAddr  = issue ? addr_q[cnt_q] : '0;
        o_validRam = (state_q == S_DONE);
        o_busy     = (state_q != S_IDLE);
    end

    // ----------------------------------------------------------- datapath
    always_comb begin
        addr_d     = addr_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        vld_pipe_d = vld_pipe_q;
        idx_pipe_d = idx_pipe_q;

        if (start_acc) begin
            addr_d = i_addrRead;
            last_d = i_mask ? IDX_W'(NUM_LANES - 1) : '0;
            cnt_d  = '0;
        end else if (issue) begin
            cnt_d = cnt_q + IDX_W'(1);
        end

        vld_pipe_d[0] = issue;
        idx_pipe_d[0] = cnt_q;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            idx_pipe_d[i] = idx_pipe_q[i-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            addr_q     <= '0;
            last_q     <= '0;
            cnt_q      <= '0;
            vld_pipe_q <= '0;
            idx_pipe_q <= '0;
        end else begin
            addr_q     <= addr_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            vld_pipe_q <= vld_pipe_d;
            idx_pipe_q <= idx_pipe_d;
        end
    end

    // ------------------------------------------------------ lane capture
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        multi_read_responder_lane #(.DATA_W(DATA_W)) u_lane (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_clr   (start_acc),
            .i_wr    (cap_en && (cap_idx == IDX_W'(g))),
            .i_wdata (i_memData),
            .o_data  (lane_data[g])
        );
    end

    assign o_data = lane_data;
endmodule

// File: tb/tb_multi_read_responder.sv
module tb_multi_read_responder;
    localparam int AW = 12;
    localparam int DW = 16;
    localparam int NL = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT with RD_LATENCY = 1
    logic            start1 = 1'b0, mask1 = 1'b0;
    logic [NL*AW-1:0] addr1 = '0;
    logic [AW-1:0]   maddr1;
    logic            mrd1, valid1, busy1;
    logic [DW-1:0]   mdata1 = '0;
    logic [NL*DW-1:0] data1;

    // DUT with RD_LATENCY = 3
    logic            start3 = 1'b0, mask3 = 1'b0;
    logic [NL*AW-1:0] addr3 = '0;
    logic [AW-1:0]   maddr3;
    logic            mrd3, valid3, busy3;
    logic [DW-1:0]   mdata3 = '0;
    logic [NL*DW-1:0] data3;

    multi_read_responder #(.ADDR_W(AW), .DATA_W(DW), .NUM_LANES(NL), .RD_LATENCY(1)) dut1 (
        .i_clk(clk), .i_reset(rst_n), .i_startRam(start1), .i_addrRead(addr1),
        .i_mask(mask1), .o_memAddr(maddr1), .o_memRead(mrd1), .i_memData(mdata1),
        .o_data(data1), .o_validRam(valid1), .o_busy(busy1));

    multi_read_responder #(.ADDR_W(AW), .DATA_W(DW), .NUM_LANES(NL), .RD_LATENCY(3)) dut3 (
        .i_clk(clk), .i_reset(rst_n), .i_startRam(start3), .i_addrRead(addr3),
        .i_mask(mask3), .o_memAddr(maddr3), .o_memRead(mrd3), .i_memData(mdata3),
        .o_data(data3), .o_validRam(valid3), .o_busy(busy3));

    // BRAM model: mem[a] = a + 100
    logic [DW-1:0] mem [0:4095];
    initial for (int a = 0; a < 4096; a++) mem[a] = DW'(a + 100);

    always @(posedge clk) if (mrd1) mdata1 <= mem[maddr1];

    logic [DW-1:0] p3a = '0, p3b = '0;
    always @(posedge clk) begin
        p3a    <= mem[maddr3];
        p3b    <= p3a;
        mdata3 <= p3b;
    end

    // Which DUT the directed tasks look at
    logic sel3 = 1'b0;
    wire [NL*DW-1:0] s_data  = sel3 ? data3  : data1;
    wire             s_valid = sel3 ? valid3 : valid1;
    wire             s_busy  = sel3 ? busy3  : busy1;

    // Activity recorders
    int rd_addr_q[$];
    int rd_cyc_q[$];
    int pulse_q[$];
    always @(negedge clk) begin
        if (mrd1) begin rd_addr_q.push_back(int'(maddr1)); rd_cyc_q.push_back(cyc); end
        if (mrd3) begin rd_addr_q.push_back(int'(maddr3)); rd_cyc_q.push_back(cyc); end
        if (valid1 || valid3) pulse_q.push_back(cyc);
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [NL*AW-1:0] rand_addrs();
        logic [NL*AW-1:0] r;
        for (int k = 0; k < NL; k++) r[k*AW +: AW] = AW'($urandom_range(0, 4095));
        return r;
    endfunction

    // Reference: every fetched lane holds its memory word, masked lanes are 0.
    function automatic logic [NL*DW-1:0] model_data(input logic [NL*AW-1:0] a, input logic m);
        logic [NL*DW-1:0] r;
        r = '0;
        for (int k = 0; k < NL; k++)
            if (m || k == 0) r[k*DW +: DW] = mem[a[k*AW +: AW]];
        return r;
    endfunction

    task automatic do_req(input logic s3, input logic [NL*AW-1:0] a, input logic m, input string tag);
        int c0, n, lat, rb, pb, wn;
        logic seen;
        lat  = s3 ? 3 : 1;
        n    = m ? NL : 1;
        sel3 = s3;
        rb   = rd_addr_q.size();
        pb   = pulse_q.size();
        if (s3) begin start3 = 1'b1; addr3 = a; mask3 = m; end
        else    begin start1 = 1'b1; addr1 = a; mask1 = m; end
        c0 = cyc;
        tick();
        start1 = 1'b0; start3 = 1'b0;
        addr1 = rand_addrs(); addr3 = rand_addrs();
        mask1 = 1'($urandom); mask3 = 1'($urandom);
        chk({tag, "_busy"}, s_busy, 1);
        seen = 1'b0;
        wn   = 0;
        while (!seen && wn < 60) begin
            if (s_valid) seen = 1'b1;
            else begin tick(); wn++; end
        end
        chk({tag, "_valid_seen"}, seen, 1);
        if (seen) begin
            chk({tag, "_latency"}, cyc - c0, n + lat + 1);
            chk({tag, "_data"}, s_data, model_data(a, m));
            tick();
            chk({tag, "_pulse_width"}, s_valid, 0);
            chk({tag, "_busy_after"}, s_busy, 0);
        end
        chk({tag, "_nreads"}, rd_addr_q.size() - rb, n);
        for (int i = 0; i < n && rb + i < rd_addr_q.size(); i++) begin
            chk({tag, "_rd_addr"}, rd_addr_q[rb+i], a[i*AW +: AW]);
            chk({tag, "_rd_cycle"}, rd_cyc_q[rb+i], c0 + 1 + i);
        end
        chk({tag, "_npulses"}, pulse_q.size() - pb, 1);
    endtask

    initial begin
        logic [NL*AW-1:0] a;
        int s, t, rb, pb, wn, np;
        int exp_p[$];

        // Reset and idle
        tick(); tick();
        chk("rst_data1", data1, 0);
        chk("rst_ctl1", {mrd1, maddr1, valid1, busy1}, 0);
        chk("rst_ctl3", {mrd3, maddr3, valid3, busy3, data3}, 0);
        rst_n = 1'b1;
        repeat (5) tick();
        chk("idle_reads", rd_addr_q.size(), 0);
        chk("idle_pulses", pulse_q.size(), 0);
        chk("idle_outs", {mrd1, maddr1, valid1, busy1, data1}, 0);

        // Addresses 0..8, all lanes
        for (int k = 0; k < NL; k++) a[k*AW +: AW] = AW'(k);
        do_req(1'b0, a, 1'b1, "seq0_8");

        // Top-of-range addresses, lane 0 only; started right after DONE
        for (int k = 0; k < NL; k++) a[k*AW +: AW] = AW'(4095 - k);
        do_req(1'b0, a, 1'b0, "top_mask0");
        chk("top_lane0", data1[DW-1:0], DW'(4195));

        // Start held high for 30 cycles
        sel3 = 1'b0;
        rb = rd_addr_q.size();
        pb = pulse_q.size();
        a = rand_addrs();
        start1 = 1'b1; addr1 = a; mask1 = 1'b1;
        s = cyc;
        repeat (30) tick();
        start1 = 1'b0;
        repeat (40) tick();
        exp_p.delete();
        t = s;
        while (t <= s + 29) begin
            exp_p.push_back(t + NL + 2);
            t += NL + 3;
        end
        np = pulse_q.size() - pb;
        chk("held_npulses", np, exp_p.size());
        for (int i = 0; i < exp_p.size() && i < np; i++)
            chk("held_pulse_cycle", pulse_q[pb+i], exp_p[i]);
        chk("held_nreads", rd_addr_q.size() - rb, NL * exp_p.size());
        chk("held_data", data1, model_data(a, 1'b1));

        // Reset while lane 4 is being issued
        a = rand_addrs();
        rb = rd_addr_q.size();
        pb = pulse_q.size();
        start1 = 1'b1; addr1 = a; mask1 = 1'b1;
        tick();
        start1 = 1'b0;
        wn = 0;
        while (rd_addr_q.size() - rb < 5 && wn < 20) begin tick(); wn++; end
        chk("mid_lane4_addr", {mrd1, maddr1}, {1'b1, a[4*AW +: AW]});
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data", data1, 0);
        chk("mid_rst_ctl", {mrd1, maddr1, valid1, busy1}, 0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("mid_no_pulse", pulse_q.size() - pb, 0);
        do_req(1'b0, rand_addrs(), 1'b0, "post_rst_m0");
        do_req(1'b0, rand_addrs(), 1'b1, "post_rst_m1");

        // Three-cycle read latency with duplicate addresses
        for (int k = 0; k < NL; k++) a[k*AW +: AW] = (k < 3) ? AW'(7) : AW'(k - 3);
        do_req(1'b1, a, 1'b1, "lat3_dup");

        // Randomized requests on both latencies
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            do_req(1'b0, rand_addrs(), 1'($urandom), "rnd_l1");
        end
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            do_req(1'b1, rand_addrs(), 1'($urandom), "rnd_l3");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multi_read_responder.md
Name: multi_read_responder

Overview:
- RAM-side responder for the 9-lane windowed read controllers (average/pooling control).
- Accepts one start pulse with 9 packed read addresses and a mask, then serializes the reads into a single-port synchronous BRAM.
- Collects the returned words into a packed output bus and pulses o_validRam once all lanes are filled.
- Sits between the layer controller (start/address side) and the feature-map BRAM.

Parameters:
- ADDR_W, 12, width of one lane address and of the BRAM address.
- DATA_W, 16, width of one BRAM word / lane datum.
- NUM_LANES, 9, number of addresses per request.
- RD_LATENCY, 1, BRAM read latency in cycles (1..3).

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous active-low reset.
- i_startRam  in  1  request strobe, sampled in IDLE only.
- i_addrRead  in  NUM_LANES*ADDR_W  packed addresses; lane k = bits [k*ADDR_W +: ADDR_W].
- i_mask  in  1  1 = fetch all lanes; 0 = fetch lane 0 only, lanes 1..8 return zero.
- o_memAddr  out  ADDR_W  BRAM read address.
- o_memRead  out  1  BRAM read enable.
- i_memData  in  DATA_W  BRAM read data, valid RD_LATENCY cycles after o_memRead.
- o_data  out  NUM_LANES*DATA_W  packed results; lane k = bits [k*DATA_W +: DATA_W].
- o_validRam  out  1  one-cycle pulse: o_data complete.
- o_busy  out  1  high from start acceptance until the cycle after o_validRam.

Behaviour:
- Reset (asynchronous, active-low, any time including mid-request):
  - state = IDLE; all capture registers and o_data = 0.
  - o_memAddr = 0; o_memRead = 0; o_validRam = 0; o_busy = 0.
  - In-flight BRAM returns are discarded.
- State IDLE:
  - If i_startRam = 1: latch i_addrRead and i_mask, set lastLane = mask ? NUM_LANES-1 : 0, clear o_data, go to ISSUE.
  - Otherwise remain in IDLE.
- State ISSUE:
  - Each cycle: o_memRead = 1, o_memAddr = latched address of issue counter k; k increments.
  - After lane lastLane is issued, go to DRAIN.
  - A RD_LATENCY-deep shift register carries {valid, lane index} alongside each read.
- State DRAIN:
  - Wait until the capture pipe is empty (last lane captured), then go to DONE.
  - o_memRead = 0 throughout.
- Capture:
  - When a pipe entry emerges with valid = 1, write i_memData into lane slot [idx].
  - This happens in ISSUE and DRAIN.
- State DONE:
  - o_validRam = 1 for exactly one cycle, then return to IDLE.
- o_data hold rules:
  - o_data holds its value until the next accepted start, which clears it to 0.
  - Masked lanes therefore read 0.
- Latency: with start sampled in cycle c0, o_validRam is high in cycle c0 + n + RD_LATENCY + 1, where n = 9 (mask = 1) or 1 (mask = 0).
- i_startRam while busy (ISSUE/DRAIN/DONE) is ignored; no queuing.
- Start in the cycle right after DONE is accepted (IDLE).
- Addresses are used as-is, with no bounds check.
  - Duplicate addresses are fetched independently.
  - Address 4095 is legal.
- Address and mask inputs are don't-care outside the start cycle.
- o_busy = (state != IDLE).

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, o_memRead never high.
- BRAM preloaded mem[a] = a+100; start with addresses 0..8, mask = 1, RD_LATENCY = 1 ->
  - o_memAddr steps 0..8 over 9 consecutive cycles.
  - o_validRam pulses at c0+11.
  - o_data lanes = 100..108.
- Start with lane addresses 4095,4094,...,4087 and mask = 0 ->
  - exactly one read, at 4095.
  - o_validRam at c0+3.
  - lane0 = mem[4095]; lanes 1..8 = 0.
- i_startRam held high for 30 cycles, mask = 1 ->
  - back-to-back requests separated by exactly one IDLE cycle.
  - each request produces one o_validRam pulse.
  - starts during busy are not double-counted.
- i_reset pulled low during ISSUE at lane 4 ->
  - all outputs 0 asynchronously.
  - after release, a fresh request returns correct data with no stale lanes.
- RD_LATENCY = 3, addresses {7,7,7,0,1,2,3,4,5} ->
  - o_validRam at c0+13.
  - lanes 0..2 = mem[7]; remaining lanes match their memory.
